// File: rtl/vend_pkg.sv
// Shared types for the vending-machine coin arbiter.
// Coin codes and the arbiter FSM state encoding.
package vend_pkg;

    typedef logic [1:0] coin_t;

    localparam coin_t COIN_NONE = 2'b00;
    localparam coin_t COIN_A    = 2'b01;
    localparam coin_t COIN_B    = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/vend_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N; returns one-hot grant, its index and any-valid.
module vend_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    always_comb begin
        int t;
        logic [IW-1:0] j;
        t     = 0;
        j     = '0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            t = int'(ptr) + k;
            if (t >= N) t = t - N;
            j = t[IW-1:0];
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/vend_coin_arbiter.sv
// Round-robin coin arbiter with per-customer ownership lock and vend counter.
// Optional HOLD idle timeout enabled by defining VEND_ARB_TIMEOUT_EN.
module vend_coin_arbiter
    import vend_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ-1:0][1:0]    req_coin,
    output logic [NREQ-1:0]         req_ready,
    output logic [1:0]              vm_in,
    input  logic                    vm_out,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    owner_vld,
    output logic [15:0]             vend_cnt
);

    localparam int IW = $clog2(NREQ);
    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

    if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 15 ||
        TIMEOUT < 1) begin : g_param_chk
        $error("vend_coin_arbiter: parameter out of range");
    end

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          owner_vld_q, owner_vld_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]   vend_cnt_q, vend_cnt_d;
    coin_t         vm_in_q, vm_in_d;
    logic [3:0]    gap_q, gap_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [IW-1:0]   ptr_nxt;
    coin_t           own_coin;

`ifdef VEND_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_q, to_d;
`endif

    vend_rr_pick #(.N(NREQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_gnt),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign ptr_nxt  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign own_coin = req_coin[owner_q];

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        rr_ptr_d    = rr_ptr_q;
        gap_d       = gap_q;
        vm_in_d     = COIN_NONE;
        req_ready   = '0;
        vend_cnt_d  = vend_cnt_q + {15'd0, vm_out};
`ifdef VEND_ARB_TIMEOUT_EN
        to_d        = '0;
`endif
        // A vend releases ownership immediately; the FSM drains ISSUE/GAP first
        if (vm_out && owner_vld_q) begin
            owner_vld_d = 1'b0;
            rr_ptr_d    = ptr_nxt;
        end
        unique case (state_q)
            IDLE: begin
                req_ready = pick_gnt;
                if (pick_any) begin
                    owner_d     = pick_idx;
                    owner_vld_d = 1'b1;
                    if (req_coin[pick_idx] != COIN_NONE) begin
                        vm_in_d = req_coin[pick_idx];
                        state_d = ISSUE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            ISSUE: begin
                state_d = GAP;
                gap_d   = GAP_INIT;
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = owner_vld_d ? HOLD : IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            HOLD: begin
                if (vm_out) begin
                    state_d = IDLE;
                end else if (req_valid[owner_q]) begin
                    req_ready[owner_q] = 1'b1;
                    if (own_coin != COIN_NONE) begin
                        vm_in_d = own_coin;
                        state_d = ISSUE;
                    end
                end
`ifdef VEND_ARB_TIMEOUT_EN
                else if (to_q == TW'(TIMEOUT - 1)) begin
                    owner_vld_d = 1'b0;
                    rr_ptr_d    = ptr_nxt;
                    state_d     = IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            rr_ptr_q    <= '0;
            vend_cnt_q  <= '0;
            vm_in_q     <= COIN_NONE;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            vend_cnt_q  <= vend_cnt_d;
            vm_in_q     <= vm_in_d;
            gap_q       <= gap_d;
        end
    end

`ifdef VEND_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) to_q <= '0;
        else       to_q <= to_d;
    end
`endif

    assign vm_in     = vm_in_q;
    assign owner     = owner_q;
    assign owner_vld = owner_vld_q;
    assign vend_cnt  = vend_cnt_q;

endmodule

// File: tb/tb_vend_coin_arbiter.sv
// Scoreboard bench for vend_coin_arbiter: directed scenarios then random
// traffic against a cycle-level behavioural model of the arbitration rules.
module tb_vend_coin_arbiter;
    import vend_pkg::*;

    localparam int N  = 4;
    localparam int G  = 2;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0][1:0] req_coin;
    logic [N-1:0]     req_ready;
    logic [1:0]       vm_in;
    logic             vm_out;
    logic [1:0]       owner;
    logic             owner_vld;
    logic [15:0]      vend_cnt;

    always #5 clk = ~clk;

    vend_coin_arbiter #(
        .NREQ(N), .GAP_CYCLES(G), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_coin(req_coin), .req_ready(req_ready),
        .vm_in(vm_in), .vm_out(vm_out),
        .owner(owner), .owner_vld(owner_vld), .vend_cnt(vend_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [1:0] coin;
        int         at;
    } exp_t;
    exp_t sb[$];

    // Reference model: blocked-cycle countdown, ownership flag, rr pointer
    int          m_busy;
    int          m_owner;
    int          m_ptr;
    bit          m_ovld;
    logic [15:0] m_cnt;
`ifdef VEND_ARB_TIMEOUT_EN
    int          m_idle;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic m_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_ovld  = 1'b0;
        m_cnt   = '0;
`ifdef VEND_ARB_TIMEOUT_EN
        m_idle  = 0;
`endif
    endtask

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] v,
                                                 input logic vo);
        logic [N-1:0] r;
        r = '0;
        if (m_busy > 0) return r;
        if (!m_ovld) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (v[j]) begin
                    r[j] = 1'b1;
                    return r;
                end
            end
            return r;
        end
        if (vo) return r;
        r[m_owner] = v[m_owner];
        return r;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [2*N-1:0] c,
                        input logic vo);
        logic [N-1:0] er;
        bit           xf, was_ovld, hold;
        int           idx;
        logic [1:0]   ccoin;
        @(posedge clk);
        #1;
        cyc++;
        req_valid = v;
        req_coin  = c;
        vm_out    = vo;
        @(negedge clk);
        er = model_ready(v, vo);
        chk("req_ready", int'(req_ready), int'(er));
        chk("owner", int'(owner), m_owner);
        chk("owner_vld", int'(owner_vld), int'(m_ovld));
        chk("vend_cnt", int'(vend_cnt), int'(m_cnt));
        xf  = (er & v) != '0;
        idx = 0;
        for (int i = 0; i < N; i++) if (er[i]) idx = i;
        ccoin    = c[2*idx +: 2];
        was_ovld = m_ovld;
        hold     = m_ovld && (m_busy == 0);
        if (vo) begin
            m_cnt++;
            if (m_ovld) begin
                m_ovld = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
        end
        if (xf) begin
            if (!was_ovld) begin
                m_owner = idx;
                m_ovld  = 1'b1;
            end
            if (ccoin != COIN_NONE) begin
                m_busy = 1 + G;
                sb.push_back('{coin: ccoin, at: cyc + 1});
            end
        end else if (m_busy > 0) begin
            m_busy--;
        end
`ifdef VEND_ARB_TIMEOUT_EN
        if (hold && !xf && !vo) begin
            m_idle++;
            if (m_idle == TO) begin
                m_ovld = 1'b0;
                m_ptr  = (m_owner + 1) % N;
                m_idle = 0;
            end
        end else begin
            m_idle = 0;
        end
`else
        if (hold && was_ovld && m_busy < 0) m_busy = 0;
`endif
    endtask

    // Monitor: every nonzero vm_in must match the next queued coin and cycle
    always @(negedge clk) begin
        if (mon_en) begin
            if (vm_in != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("vm_in_unexpected", int'(vm_in), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("vm_in_coin", int'(vm_in), int'(e.coin));
                    chk("vm_in_cycle", cyc, e.at);
                end
            end else if (sb.size() > 0 && sb[0].at <= cyc) begin
                chk("vm_in_missing", int'(vm_in), int'(sb[0].coin));
                void'(sb.pop_front());
            end
        end
    end

    function automatic logic [1:0] rnd_coin();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return COIN_NONE;
        if (r <= 3) return COIN_A;
        if (r <= 6) return COIN_B;
        return 2'b11;
    endfunction

    initial begin
        bit found;
        logic [2*N-1:0] rc;
        req_valid = '0;
        req_coin  = '0;
        vm_out    = 1'b0;
        reset     = 1'b1;
        m_reset();
        #1;
        chk("rst_vm_in", int'(vm_in), 0);
        chk("rst_ready", int'(req_ready), 0);
        chk("rst_owner_vld", int'(owner_vld), 0);
        chk("rst_vend_cnt", int'(vend_cnt), 0);
        chk("rst_owner", int'(owner), 0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Requesters 1 and 2 valid from rr_ptr 0: requester 1 wins
        step(4'b0110, {2'b00, 2'b10, 2'b01, 2'b00}, 1'b0);
        chk("first_grant", int'(req_ready), 4'b0010);
        // Requester 2 blocked while 1 owns
        repeat (20) step(4'b0100, {2'b00, 2'b10, 2'b00, 2'b00}, 1'b0);
        chk("lock_owner", int'(owner), 1);
        step(4'b0000, '0, 1'b1);
        step(4'b0100, {2'b00, 2'b01, 2'b00, 2'b00}, 1'b0);
        chk("vend_after_rel", int'(vend_cnt), 1);
        chk("next_winner", int'(req_ready), 4'b0100);
        repeat (G + 2) step(4'b0000, '0, 1'b0);
        // Owner request collides with vend: release wins
        step(4'b0100, {2'b00, 2'b10, 2'b00, 2'b00}, 1'b1);
        chk("collide_ready", int'(req_ready), 0);
        step(4'b0000, '0, 1'b0);
        chk("collide_rel", int'(owner_vld), 0);
        chk("collide_cnt", int'(vend_cnt), 2);
        // Zero coin from requester 3 takes the lock without issuing
        step(4'b1000, {2'b00, 2'b00, 2'b00, 2'b00}, 1'b0);
        step(4'b0000, '0, 1'b0);
        chk("zero_coin_owner", int'(owner), 3);
        chk("zero_coin_vm_in", int'(vm_in), 0);
        // Long idle hold
        repeat (1000) step(4'b0000, '0, 1'b0);
`ifdef VEND_ARB_TIMEOUT_EN
        chk("long_hold", int'(owner_vld), 0);
`else
        chk("long_hold", int'(owner_vld), 1);
`endif
        step(4'b0000, '0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) rc[2*k +: 2] = rnd_coin();
            step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15) | 4'h5),
                 rc, ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset while a coin is on vm_in
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            for (int k = 0; k < N; k++) rc[2*k +: 2] = COIN_B;
            step(4'b1111, rc, 1'b0);
            if (vm_in != 2'b00) found = 1'b1;
        end
        chk("found_issue", int'(found), 1);
        #1;
        mon_en    = 1'b0;
        req_valid = '0;
        reset     = 1'b1;
        #1;
        chk("mid_rst_vm_in", int'(vm_in), 0);
        chk("mid_rst_owner_vld", int'(owner_vld), 0);
        chk("mid_rst_vend_cnt", int'(vend_cnt), 0);
        chk("mid_rst_ready", int'(req_ready), 0);
        sb.delete();
        m_reset();
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        step(4'b0001, {2'b00, 2'b00, 2'b00, 2'b01}, 1'b0);
        repeat (G + 3) step(4'b0000, '0, 1'b0);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
